// File: rtl/systolic_matmul_stream.sv
// Output-stationary N_SIZE x N_SIZE systolic multiplier computing C = A x B with programmable K.
// Operand beats stream in on valid/ready; C rows stream out on a backpressured valid/ready port.
module systolic_matmul_stream #(
  parameter int DATAWIDTH = 16,
  parameter int N_SIZE    = 4,
  parameter int K_MAX     = 64,
  parameter int ACCW      = 2*DATAWIDTH+$clog2(K_MAX)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [$clog2(K_MAX+1)-1:0]    cfg_k,
  input  logic                          cfg_signed,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_SIZE*DATAWIDTH-1:0]   a_col,
  input  logic [N_SIZE*DATAWIDTH-1:0]   b_row,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_SIZE*ACCW-1:0]        out_data,
  output logic [$clog2(N_SIZE)-1:0]     out_row,
  output logic                          out_last,
  output logic                          busy
);
  localparam int KW  = $clog2(K_MAX+1);
  localparam int RW  = $clog2(N_SIZE);
  localparam int DCW = $clog2(2*N_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_OUTPUT} state_t;

  state_t                state_q, state_d;
  logic [KW-1:0]         k_q, k_d, beat_q, beat_d;
  logic                  signed_q, signed_d;
  logic [DCW-1:0]        drain_q, drain_d;
  logic                  load_first, load_next, finish;
  logic                  accept, out_hs;
  logic                  out_valid_q, out_last_q;
  logic [RW-1:0]         out_row_q, row_sel;
  logic [N_SIZE*ACCW-1:0] out_data_q, row_vec;
  logic [N_SIZE*DATAWIDTH-1:0] a_feed, b_feed;

  logic [DATAWIDTH-1:0]  a_edge   [N_SIZE];
  logic [DATAWIDTH-1:0]  b_edge   [N_SIZE];
  logic [DATAWIDTH-1:0]  a_in     [N_SIZE][N_SIZE];
  logic [DATAWIDTH-1:0]  b_in     [N_SIZE][N_SIZE];
  logic [DATAWIDTH-1:0]  a_pass_q [N_SIZE][N_SIZE-1];
  logic [DATAWIDTH-1:0]  b_pass_q [N_SIZE-1][N_SIZE];
  logic [ACCW-1:0]       acc_q    [N_SIZE][N_SIZE];

  function automatic logic [KW-1:0] clamp_k(input logic [KW-1:0] k);
    if (k == '0) return KW'(1);
    if (k > KW'(K_MAX)) return KW'(K_MAX);
    return k;
  endfunction

  // Product formed at 2*DATAWIDTH bits, then sign- or zero-extended into the accumulator width.
  function automatic logic [ACCW-1:0] mac_term(input logic [DATAWIDTH-1:0] a,
                                              input logic [DATAWIDTH-1:0] b,
                                              input logic sg);
    logic [2*DATAWIDTH-1:0] ae, be, p;
    ae = {{DATAWIDTH{sg & a[DATAWIDTH-1]}}, a};
    be = {{DATAWIDTH{sg & b[DATAWIDTH-1]}}, b};
    p  = ae * be;
    return {{(ACCW-2*DATAWIDTH){sg & p[2*DATAWIDTH-1]}}, p};
  endfunction

  assign in_ready  = rst_n & ((state_q == S_IDLE) | (state_q == S_LOAD));
  assign busy      = (state_q != S_IDLE);
  assign accept    = in_valid & in_ready;
  assign out_hs    = out_valid_q & out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_last  = out_last_q;
  assign a_feed    = accept ? a_col : '0;
  assign b_feed    = accept ? b_row : '0;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    beat_d     = beat_q;
    signed_d   = signed_q;
    drain_d    = drain_q;
    load_first = 1'b0;
    load_next  = 1'b0;
    finish     = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        k_d      = clamp_k(cfg_k);
        signed_d = cfg_signed;
        beat_d   = KW'(1);
        drain_d  = '0;
        state_d  = (clamp_k(cfg_k) == KW'(1)) ? S_DRAIN : S_LOAD;
      end
      S_LOAD: if (accept) begin
        if (beat_q == k_q - KW'(1)) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          beat_d = beat_q + KW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == DCW'(2*N_SIZE-1)) begin
          state_d    = S_OUTPUT;
          load_first = 1'b1;
          drain_d    = '0;
        end else begin
          drain_d = drain_q + DCW'(1);
        end
      end
      S_OUTPUT: if (out_hs) begin
        if (out_last_q) begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end else begin
          load_next = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      k_q      <= KW'(1);
      beat_q   <= '0;
      signed_q <= 1'b0;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      beat_q   <= beat_d;
      signed_q <= signed_d;
      drain_q  <= drain_d;
    end
  end

  assign row_sel = load_first ? '0 : out_row_q + RW'(1);

  always_comb begin
    row_vec = '0;
    for (int j = 0; j < N_SIZE; j++) row_vec[j*ACCW +: ACCW] = acc_q[row_sel][j];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else if (load_first || load_next) begin
      out_valid_q <= 1'b1;
      out_row_q   <= row_sel;
      out_last_q  <= (row_sel == RW'(N_SIZE-1));
      out_data_q  <= row_vec;
    end else if (finish) begin
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end
  end

  // Input skew: one common capture stage plus i extra stages for row/column i.
  for (genvar gi = 0; gi < N_SIZE; gi++) begin : g_skew
    logic [DATAWIDTH-1:0] a_sk_q [0:gi];
    logic [DATAWIDTH-1:0] b_sk_q [0:gi];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int d = 0; d <= gi; d++) begin
          a_sk_q[d] <= '0;
          b_sk_q[d] <= '0;
        end
      end else begin
        a_sk_q[0] <= a_feed[gi*DATAWIDTH +: DATAWIDTH];
        b_sk_q[0] <= b_feed[gi*DATAWIDTH +: DATAWIDTH];
        for (int d = 1; d <= gi; d++) begin
          a_sk_q[d] <= a_sk_q[d-1];
          b_sk_q[d] <= b_sk_q[d-1];
        end
      end
    end
    assign a_edge[gi] = a_sk_q[gi];
    assign b_edge[gi] = b_sk_q[gi];
  end

  always_comb begin
    for (int i = 0; i < N_SIZE; i++) begin
      a_in[i][0] = a_edge[i];
      b_in[0][i] = b_edge[i];
      for (int j = 1; j < N_SIZE; j++) begin
        a_in[i][j] = a_pass_q[i][j-1];
        b_in[j][i] = b_pass_q[j-1][i];
      end
    end
  end

  // PE array: a moves right, b moves down, every PE accumulates each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SIZE; i++)
        for (int j = 0; j < N_SIZE; j++) acc_q[i][j] <= '0;
      for (int i = 0; i < N_SIZE; i++)
        for (int j = 0; j < N_SIZE-1; j++) a_pass_q[i][j] <= '0;
      for (int i = 0; i < N_SIZE-1; i++)
        for (int j = 0; j < N_SIZE; j++) b_pass_q[i][j] <= '0;
    end else begin
      for (int i = 0; i < N_SIZE; i++)
        for (int j = 0; j < N_SIZE; j++)
          acc_q[i][j] <= finish ? '0 : acc_q[i][j] + mac_term(a_in[i][j], b_in[i][j], signed_q);
      for (int i = 0; i < N_SIZE; i++)
        for (int j = 0; j < N_SIZE-1; j++) a_pass_q[i][j] <= a_in[i][j];
      for (int i = 0; i < N_SIZE-1; i++)
        for (int j = 0; j < N_SIZE; j++) b_pass_q[i][j] <= b_in[i][j];
    end
  end

endmodule

// File: tb/tb_systolic_matmul_stream.sv
// Scoreboard bench for systolic_matmul_stream: expected C rows are queued as jobs are driven.
module tb_systolic_matmul_stream;
  localparam int DW = 16;
  localparam int N  = 4;
  localparam int KM = 64;
  localparam int AW = 2*DW+$clog2(KM);
  localparam int KW = $clog2(KM+1);
  localparam int RW = $clog2(N);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [KW-1:0]     cfg_k = '0;
  logic              cfg_signed = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N*DW-1:0]   a_col = '0;
  logic [N*DW-1:0]   b_row = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [N*AW-1:0]   out_data;
  logic [RW-1:0]     out_row;
  logic              out_last;
  logic              busy;

  systolic_matmul_stream #(.DATAWIDTH(DW), .N_SIZE(N), .K_MAX(KM)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_k(cfg_k), .cfg_signed(cfg_signed),
    .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*AW-1:0] data;
    int              row;
    bit              last;
  } row_t;

  row_t exp_q[$];
  int   A [N][KM];
  int   B [KM][N];
  int   checks = 0;
  int   errors = 0;

  task automatic fill(input int av, input int bv);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < KM; k++) begin
        A[i][k] = av;
        B[k][i] = bv;
      end
  endtask

  task automatic push_expected(input int k, input bit sg);
    row_t e;
    logic [DW-1:0] av, bv;
    longint s, xa, xb;
    for (int i = 0; i < N; i++) begin
      e.data = '0;
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int kk = 0; kk < k; kk++) begin
          av = A[i][kk][DW-1:0];
          bv = B[kk][j][DW-1:0];
          xa = sg ? longint'($signed(av)) : longint'(av);
          xb = sg ? longint'($signed(bv)) : longint'(bv);
          s += xa * xb;
        end
        e.data[j*AW +: AW] = s[AW-1:0];
      end
      e.row  = i;
      e.last = (i == N-1);
      exp_q.push_back(e);
    end
  endtask

  // Returns just after the edge that accepts the final beat.
  task automatic drive_job(input int k, input int cfgk, input bit sg,
                           input int gap_at, input int gap_len);
    push_expected(k, sg);
    for (int b = 0; b < k; b++) begin
      if (b == gap_at && gap_len > 0) begin
        in_valid = 1'b0;
        a_col = {N{16'hA5A5}};
        b_row = {N{16'h5A5A}};
        repeat (gap_len) begin @(posedge clk); #1; end
      end
      in_valid   = 1'b1;
      cfg_k      = (b == 0) ? KW'(cfgk) : KW'(3);
      cfg_signed = (b == 0) ? sg : ~sg;
      for (int i = 0; i < N; i++) begin
        a_col[i*DW +: DW] = A[i][b][DW-1:0];
        b_row[i*DW +: DW] = B[b][i][DW-1:0];
      end
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL in_ready_beat%0d: got %b want 1", b, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    a_col = '0;
    b_row = '0;
  endtask

  task automatic collect(input string name, input int lat_exp,
                         input int stall_row, input int stall_len);
    int cnt;
    row_t e;
    logic [N*AW-1:0] hold;
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 300) begin @(posedge clk); #1; cnt++; end
    if (lat_exp >= 0) begin
      checks++;
      if (cnt != lat_exp) begin
        errors++;
        $display("FAIL %s_latency: got %0d cycles want %0d", name, cnt, lat_exp);
      end
    end
    for (int r = 0; r < N; r++) begin
      cnt = 0;
      while (out_valid !== 1'b1 && cnt < 50) begin @(posedge clk); #1; cnt++; end
      checks++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s_row%0d_timeout: out_valid %b queued %0d want valid row", name, r,
                 out_valid, exp_q.size());
        return;
      end
      e = exp_q.pop_front();
      checks++;
      if (out_data !== e.data) begin
        errors++;
        $display("FAIL %s_data_r%0d: got %h want %h", name, r, out_data, e.data);
      end
      checks++;
      if (out_row !== RW'(e.row) || out_last !== e.last) begin
        errors++;
        $display("FAIL %s_rowidx_r%0d: got row %0d last %b want row %0d last %b", name, r,
                 out_row, out_last, e.row, e.last);
      end
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s_ctl_r%0d: got in_ready %b busy %b want 0 1", name, r, in_ready, busy);
      end
      if (r == stall_row) begin
        out_ready = 1'b0;
        hold = out_data;
        repeat (stall_len) begin
          @(posedge clk); #1;
          checks++;
          if (out_valid !== 1'b1 || out_data !== hold || out_row !== RW'(r) || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_stall: got valid %b row %0d in_ready %b data %h want 1 %0d 0 %h",
                     name, out_valid, out_row, in_ready, out_data, r, hold);
          end
        end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_end: got valid %b busy %b in_ready %b want 0 0 1", name, out_valid, busy,
               in_ready);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || out_row !== '0 ||
        out_last !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got rdy %b vld %b data %h row %0d last %b busy %b want all 0",
               in_ready, out_valid, out_data, out_row, out_last, busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got in_ready %b want 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_identity();
    fill(0, 0);
    for (int i = 0; i < N; i++) A[i][i] = 1;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < N; j++) B[k][j] = 4*k + j + 1;
    drive_job(4, 4, 1'b0, -1, 0);
    collect("identity", 2*N, -1, 0);
  endtask

  task automatic test_back_to_back_signed();
    fill(-2, 3);
    drive_job(3, 3, 1'b1, -1, 0);
    collect("signed", 2*N, -1, 0);
  endtask

  task automatic test_bubbles();
    fill(1, 1);
    drive_job(5, 5, 1'b0, 2, 2);
    collect("bubbles", 2*N, -1, 0);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 4; k++) begin
        A[i][k] = int'($urandom_range(0, 65535));
        B[k][i] = int'($urandom_range(0, 65535));
      end
    drive_job(4, 4, 1'b1, -1, 0);
    collect("backpressure", 2*N, 1, 10);
  endtask

  task automatic test_reset_mid_job();
    fill(1, 1);
    drive_job(4, 4, 1'b0, -1, 0);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset: got busy %b vld %b rdy %b data %h want 0 0 0 0", busy, out_valid,
               in_ready, out_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    drive_job(2, 2, 1'b0, -1, 0);
    collect("after_reset", 2*N, -1, 0);
  endtask

  task automatic test_k_limits();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        A[i][j] = int'($urandom_range(0, 65535));
        B[i][j] = int'($urandom_range(0, 65535));
      end
    drive_job(1, 0, 1'b0, -1, 0);
    collect("k_zero", 2*N, -1, 0);
    fill(32'hFFFF, 32'hFFFF);
    drive_job(KM, KM, 1'b0, -1, 0);
    collect("k_max", 2*N, -1, 0);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_back_to_back_signed();
    test_bubbles();
    test_backpressure();
    test_reset_mid_job();
    test_k_limits();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_rows: got %0d queued want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
